// File: rtl/sec_rsearch28bits.sv
// Single-error location search for an AN code: walks the powers of two mod A
// and reports the signed error location whose remainder matches the input.
module sec_rsearch28bits #(
  parameter int A    = 17619,
  parameter int LMAX = 43
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       in_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [6:0] out_l,
  output logic              out_noerr,
  output logic              out_uncorr
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the result is held unchanged while out_valid && !out_ready.
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [15:0] A16   = 16'(A);
  localparam logic [6:0]  LMAX7 = 7'(LMAX);

  state_t             state, state_nx;
  logic [14:0]        r, r_nx;
  logic [14:0]        rn, rn_nx;
  logic [14:0]        p, p_nx;
  logic [6:0]         k, k_nx;
  logic signed [6:0]  l_nx;
  logic               noerr_nx, uncorr_nx;
  logic [15:0]        p2;
  logic [15:0]        rn_full;

  assign p2        = {p, 1'b0};
  assign rn_full   = A16 - {1'b0, in_r};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx  = state;
    r_nx      = r;
    rn_nx     = rn;
    p_nx      = p;
    k_nx      = k;
    l_nx      = out_l;
    noerr_nx  = out_noerr;
    uncorr_nx = out_uncorr;
    case (state)
      IDLE: begin
        if (in_valid) begin
          r_nx      = in_r;
          rn_nx     = rn_full[14:0];
          l_nx      = '0;
          noerr_nx  = 1'b0;
          uncorr_nx = 1'b0;
          if (in_r == 15'd0) begin
            noerr_nx = 1'b1;
            state_nx = DONE;
          end else if ({1'b0, in_r} >= A16) begin
            uncorr_nx = 1'b1;
            state_nx  = DONE;
          end else begin
            k_nx     = 7'd1;
            p_nx     = 15'd1;
            state_nx = SEARCH;
          end
        end
      end
      SEARCH: begin
        // p tracks 2^(k-1) mod A; A is odd so r and rn never both match.
        if (p == r) begin
          l_nx     = $signed(k);
          state_nx = DONE;
        end else if (p == rn) begin
          l_nx     = -$signed(k);
          state_nx = DONE;
        end else if (k == LMAX7) begin
          l_nx      = '0;
          uncorr_nx = 1'b1;
          state_nx  = DONE;
        end else begin
          k_nx = k + 7'd1;
          p_nx = (p2 >= A16) ? 15'(p2 - A16) : p2[14:0];
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      rn         <= '0;
      p          <= '0;
      k          <= '0;
      out_l      <= '0;
      out_noerr  <= 1'b0;
      out_uncorr <= 1'b0;
    end else begin
      state      <= state_nx;
      r          <= r_nx;
      rn         <= rn_nx;
      p          <= p_nx;
      k          <= k_nx;
      out_l      <= l_nx;
      out_noerr  <= noerr_nx;
      out_uncorr <= uncorr_nx;
    end
  end

endmodule

// File: tb/tb_sec_rsearch28bits.sv
// Bench for sec_rsearch28bits: directed spec cases, a mid-search reset and
// random remainders checked against an arithmetic location model.
module tb_sec_rsearch28bits;
  localparam int A    = 17619;
  localparam int LMAX = 43;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [14:0]       in_r = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [6:0] out_l;
  logic              out_noerr;
  logic              out_uncorr;

  int n_vec = 0;
  int n_miss = 0;
  logic [8:0] exp_q[$];   // {l[6:0], noerr, uncorr}

  sec_rsearch28bits #(.A(A), .LMAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_noerr(out_noerr), .out_uncorr(out_uncorr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference: search location magnitudes directly with 64-bit powers of two.
  function automatic void ref_search(input int r, output int l, output int noerr,
                                     output int uncorr, output int lat);
    longint v;
    bit found;
    l = 0; noerr = 0; uncorr = 0; lat = 0; found = 0;
    if (r == 0) noerr = 1;
    else if (r >= A) uncorr = 1;
    else begin
      for (int kk = 1; kk <= LMAX; kk++) begin
        v = (longint'(1) << (kk - 1)) % A;
        if (!found && v == r)          begin l = kk;  lat = kk; found = 1; end
        else if (!found && A - v == r) begin l = -kk; lat = kk; found = 1; end
      end
      if (!found) begin uncorr = 1; lat = LMAX; end
    end
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_l", int'(out_l), int'($signed(exp_q[0][8:2])));
        check("out_noerr", int'(out_noerr), int'(exp_q[0][1]));
        check("out_uncorr", int'(out_uncorr), int'(exp_q[0][0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver
  task automatic send(input logic [14:0] r, input int hold);
    int l, nz, uc, lat, edges, guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check("idle_wait", int'(in_ready), 1);
    ref_search(int'(r), l, nz, uc, lat);
    exp_q.push_back({7'(l), 1'(nz), 1'(uc)});
    in_valid = 1'b1;
    in_r     = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < LMAX + 5) begin
      check("in_ready_search", int'(in_ready), 0);
      in_valid = 1'($urandom_range(0, 1));
      in_r     = 15'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, lat);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      in_r     = 15'($urandom);
      check("in_ready_done", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
    if (exp_q.size() != 0) begin
      check("result_consumed", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic pin(input string name, input int r, input int l_w, input int nz_w,
                     input int uc_w, input int lat_w);
    int l, nz, uc, lat;
    ref_search(r, l, nz, uc, lat);
    check({name, "_l"}, l, l_w);
    check({name, "_noerr"}, nz, nz_w);
    check({name, "_uncorr"}, uc, uc_w);
    check({name, "_lat"}, lat, lat_w);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, int'(out_valid), 0);
    check({name, "_out_l"}, int'(out_l), 0);
    check({name, "_out_noerr"}, int'(out_noerr), 0);
    check({name, "_out_uncorr"}, int'(out_uncorr), 0);
    check({name, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int kk, sel;
    logic [14:0] rr;
    longint v;

    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // hand-computed values pin the model
    pin("m15149", 15149, 16, 0, 0, 16);
    pin("m1", 1, 1, 0, 0, 1);
    pin("m17618", 17618, -1, 0, 0, 1);
    pin("m5585", 5585, -43, 0, 0, 43);
    pin("m0", 0, 0, 1, 0, 0);
    pin("m17619", 17619, 0, 0, 1, 0);
    pin("m3", 3, 0, 0, 1, 43);
    pin("m13805", 13805, 28, 0, 0, 28);

    // directed cases
    send(15'd15149, 0);
    send(15'd1, 1);
    send(15'd17618, 0);
    send(15'd5585, 2);
    send(15'd0, 0);
    send(15'd17619, 0);
    send(15'd3, 5);
    send(15'd32767, 3);

    // asynchronous reset in the middle of a search at k = 10
    in_valid = 1'b1;
    in_r     = 15'd13805;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(15'd13805, 1);

    // random remainders: mostly true single-error syndromes, some arbitrary
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        kk = $urandom_range(1, LMAX);
        v  = (longint'(1) << (kk - 1)) % A;
        rr = (sel == 0) ? 15'(v) : 15'(A - v);
      end else if (sel == 2) begin
        rr = 15'($urandom_range(0, A - 1));
      end else begin
        rr = 15'($urandom_range(A, 32767));
      end
      send(rr, $urandom_range(0, 5));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
